i2s_rx_sample_scheduler: RTL and testbench

- Sequences capture of stereo sample pairs from the I2S receiver, which is fed by the ESP32 audio link.
- Buffers the pairs in a small FIFO and releases one pair per mixer sample tick.
- Decouples the I2S frame rate from the core mixer rate. Priming rules and underrun/overrun handling give glitch-free playback into the sound mixer.

---
 rtl/i2s_rx_sample_scheduler_pkg.sv | 32 +++
 rtl/i2s_rx_sample_scheduler_sample_fifo.sv | 70 +++++++
 rtl/i2s_rx_sample_scheduler.sv | 154 +++++++++++++++
 tb/tb_i2s_rx_sample_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_rx_sample_scheduler_pkg.sv
// Shared types and widths for the I2S receive sample scheduler.
package i2s_rx_sample_scheduler_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned PAIR_W   = 2 * SAMPLE_W;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_WAIT = 2'd1,
        CAP_PUSH = 2'd2
    } cap_state_t;

    typedef enum logic {
        PRIME = 1'b0,
        PLAY  = 1'b1
    } play_state_t;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } pair_t;

    // Bundle a left/right word into one FIFO entry.
    function automatic pair_t make_pair(input logic [SAMPLE_W-1:0] l,
                                        input logic [SAMPLE_W-1:0] r);
        pair_t p;
        p.left  = l;
        p.right = r;
        return p;
    endfunction

endpackage

// File: rtl/i2s_rx_sample_scheduler_sample_fifo.sv
// Synchronous stereo-pair FIFO with registered read data and a flush input.
module i2s_rx_sample_scheduler_sample_fifo
    import i2s_rx_sample_scheduler_pkg::*;
#(
    parameter  int unsigned DEPTH   = 8,
    localparam int unsigned PTR_W   = $clog2(DEPTH),
    localparam int unsigned LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               wr_en,
    input  pair_t              wr_data,
    input  logic               rd_en,
    output pair_t              rd_data,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    pair_t              mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEVEL_W-1:0] count;
    logic               do_rd;
    logic               do_wr;

    assign full  = (count == LEVEL_W'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

    // A pop frees the slot for a same-cycle push when full; flush overrides both.
    assign do_rd = rd_en & ~empty & ~flush;
    assign do_wr = wr_en & (~full | do_rd) & ~flush;

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy counter and registered read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                rd_data <= mem[rd_ptr];
            end
            if (do_wr && !do_rd) begin
                count <= count + LEVEL_W'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - LEVEL_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2s_rx_sample_scheduler.sv
// Captures I2S stereo pairs on LRCK frames and releases them on mixer ticks.
module i2s_rx_sample_scheduler
    import i2s_rx_sample_scheduler_pkg::*;
#(
    parameter  int unsigned DEPTH            = 8,
    parameter  int unsigned PRIME_LEVEL      = 4,
    parameter  int unsigned SETTLE           = 3,
    parameter  bit          MUTE_ON_UNDERRUN = 1'b0,
    localparam int unsigned LEVEL_W          = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                rx_lrck,
    input  logic [SAMPLE_W-1:0] rx_left,
    input  logic [SAMPLE_W-1:0] rx_right,
    input  logic                out_tick,
    output logic [SAMPLE_W-1:0] out_left,
    output logic [SAMPLE_W-1:0] out_right,
    output logic                out_valid,
    output logic [LEVEL_W-1:0]  level,
    output logic                underrun,
    output logic                overrun,
    input  logic                flag_clr
);

    localparam int unsigned CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    logic              lrck_s1;
    logic              lrck_s2;
    logic              lrck_d;
    logic              frame_event;
    cap_state_t        cap_state;
    logic [CNT_W-1:0]  settle_cnt;
    play_state_t       play_state;
    logic              muted;
    logic              push;
    logic              pop;
    logic              tick_empty;
    logic              fifo_full;
    logic              fifo_empty;
    pair_t             fifo_rd_data;

    assign frame_event = lrck_s2 & ~lrck_d;
    assign push        = enable & (cap_state == CAP_PUSH);
    assign pop         = enable & (play_state == PLAY) & out_tick & ~fifo_empty;
    assign tick_empty  = enable & (play_state == PLAY) & out_tick & fifo_empty;

    // Output samples come straight from the FIFO read register; muting zeroes them.
    assign out_left  = muted ? '0 : fifo_rd_data.left;
    assign out_right = muted ? '0 : fifo_rd_data.right;

    i2s_rx_sample_scheduler_sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (~enable),
        .wr_en   (push),
        .wr_data (make_pair(rx_left, rx_right)),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Two-flop LRCK synchroniser plus edge-detect register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lrck_s1 <= 1'b0;
            lrck_s2 <= 1'b0;
            lrck_d  <= 1'b0;
        end else begin
            lrck_s1 <= rx_lrck;
            lrck_s2 <= lrck_s1;
            lrck_d  <= lrck_s2;
        end
    end

    // Capture FSM: wait SETTLE cycles after a frame event, then push one pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_state  <= CAP_IDLE;
            settle_cnt <= '0;
        end else if (!enable) begin
            cap_state  <= CAP_IDLE;
            settle_cnt <= '0;
        end else begin
            case (cap_state)
                CAP_IDLE: begin
                    if (frame_event) begin
                        cap_state  <= CAP_WAIT;
                        settle_cnt <= CNT_W'(SETTLE);
                    end
                end
                CAP_WAIT: begin
                    if (settle_cnt <= CNT_W'(1)) begin
                        cap_state  <= CAP_PUSH;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                CAP_PUSH: cap_state <= CAP_IDLE;
                default:  cap_state <= CAP_IDLE;
            endcase
        end
    end

    // Play FSM, output strobe, mute state and sticky flags (set beats clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            play_state <= PRIME;
            out_valid  <= 1'b0;
            muted      <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (flag_clr) begin
                underrun <= 1'b0;
                overrun  <= 1'b0;
            end
            if (push && fifo_full && !pop) begin
                overrun <= 1'b1;
            end
            if (!enable) begin
                play_state <= PRIME;
            end else begin
                case (play_state)
                    PRIME: begin
                        if (level >= LEVEL_W'(PRIME_LEVEL)) begin
                            play_state <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (pop) begin
                            out_valid <= 1'b1;
                            muted     <= 1'b0;
                        end else if (tick_empty) begin
                            out_valid  <= 1'b1;
                            underrun   <= 1'b1;
                            muted      <= MUTE_ON_UNDERRUN;
                            play_state <= PRIME;
                        end
                    end
                    default: play_state <= PRIME;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_sample_scheduler.sv
// Scoreboard bench for i2s_rx_sample_scheduler (DEPTH=8, PRIME_LEVEL=4, SETTLE=3, hold on underrun).
module tb_i2s_rx_sample_scheduler;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        rx_lrck;
    logic [15:0] rx_left;
    logic [15:0] rx_right;
    logic        out_tick;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic        out_valid;
    logic [3:0]  level;
    logic        underrun;
    logic        overrun;
    logic        flag_clr;

    int passed = 0;
    int total  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_pair;
    logic [15:0] last_l;
    logic [15:0] last_r;

    always #5 clk = ~clk;

    i2s_rx_sample_scheduler #(
        .DEPTH            (8),
        .PRIME_LEVEL      (4),
        .SETTLE           (3),
        .MUTE_ON_UNDERRUN (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .rx_lrck   (rx_lrck),
        .rx_left   (rx_left),
        .rx_right  (rx_right),
        .out_tick  (out_tick),
        .out_left  (out_left),
        .out_right (out_right),
        .out_valid (out_valid),
        .level     (level),
        .underrun  (underrun),
        .overrun   (overrun),
        .flag_clr  (flag_clr)
    );

    function automatic logic [15:0] lval(input int n);
        logic [31:0] t;
        t = 32'h1111 * 32'(n);
        return t[15:0];
    endfunction

    function automatic logic [15:0] rval(input int n);
        logic [31:0] t;
        t = 32'h2222 * 32'(n);
        return t[15:0];
    endfunction

    // One LRCK frame; optional tick/flag_clr aligned with the push cycle.
    // Snapshot of outputs is taken on the negedge right after the push edge.
    task automatic send_frame(input int n, input bit tick_at_push, input bit clr_at_push,
                              output logic snap_valid, output logic [15:0] snap_l,
                              output logic [15:0] snap_r, output logic [3:0] snap_level,
                              output logic snap_ovr);
        rx_left  = lval(n);
        rx_right = rval(n);
        @(negedge clk) rx_lrck = 1'b1;
        repeat (6) @(negedge clk);
        out_tick = tick_at_push;
        flag_clr = clr_at_push;
        @(negedge clk);
        out_tick   = 1'b0;
        flag_clr   = 1'b0;
        snap_valid = out_valid;
        snap_l     = out_left;
        snap_r     = out_right;
        snap_level = level;
        snap_ovr   = overrun;
        if (exp_q.size() < DEPTH) exp_q.push_back({lval(n), rval(n)});
        repeat (3) @(negedge clk);
        rx_lrck = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic frames(input int first, input int cnt);
        logic v, o;
        logic [15:0] l, r;
        logic [3:0] lv;
        for (int i = 0; i < cnt; i++) send_frame(first + i, 1'b0, 1'b0, v, l, r, lv, o);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (level !== 4'd0) $display("FAIL reset_level got %0d want 0", level); else passed++;
        total++; if (out_left !== 16'h0 || out_right !== 16'h0)
            $display("FAIL reset_out got %h/%h want 0000/0000", out_left, out_right); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else passed++;
        total++; if (underrun !== 1'b0 || overrun !== 1'b0)
            $display("FAIL reset_flags got u%b o%b want u0 o0", underrun, overrun); else passed++;
    endtask

    task automatic test_prime_play();
        frames(1, 3);
        @(negedge clk) out_tick = 1'b1;
        @(negedge clk) out_tick = 1'b0;
        total++; if (out_valid !== 1'b0 || underrun !== 1'b0)
            $display("FAIL prime_tick_ignored got v%b u%b want v0 u0", out_valid, underrun); else passed++;
        frames(4, 1);
        total++; if (level !== 4'd4) $display("FAIL prime_level got %0d want 4", level); else passed++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) out_tick = 1'b1;
            @(negedge clk) out_tick = 1'b0;
            exp_pair = exp_q.pop_front();
            total++; if (out_valid !== 1'b1 || {out_left, out_right} !== exp_pair)
                $display("FAIL play_pop%0d got v%b %h%h want v1 %h", i, out_valid, out_left, out_right, exp_pair);
            else passed++;
            @(negedge clk);
            total++; if (out_valid !== 1'b0) $display("FAIL valid_pulse%0d got %b want 0", i, out_valid); else passed++;
        end
    endtask

    task automatic test_overrun();
        logic v, o;
        logic [15:0] l, r;
        logic [3:0] lv;
        do_reset();
        frames(1, 8);
        total++; if (level !== 4'd8 || overrun !== 1'b0)
            $display("FAIL fill8 got lvl %0d o%b want 8 o0", level, overrun); else passed++;
        send_frame(9, 1'b0, 1'b0, v, l, r, lv, o);
        total++; if (overrun !== 1'b1) $display("FAIL overrun_9th got %b want 1", overrun); else passed++;
        send_frame(10, 1'b0, 1'b0, v, l, r, lv, o);
        total++; if (level !== 4'd8) $display("FAIL overrun_level got %0d want 8", level); else passed++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) out_tick = 1'b1;
            @(negedge clk) out_tick = 1'b0;
            exp_pair = exp_q.pop_front();
            {last_l, last_r} = exp_pair;
            total++; if (out_valid !== 1'b1 || {out_left, out_right} !== exp_pair)
                $display("FAIL drain%0d got v%b %h%h want v1 %h", i, out_valid, out_left, out_right, exp_pair);
            else passed++;
        end
        total++; if (level !== 4'd0) $display("FAIL drained_level got %0d want 0", level); else passed++;
    endtask

    task automatic test_underrun();
        @(negedge clk) out_tick = 1'b1;
        @(negedge clk) out_tick = 1'b0;
        total++; if (underrun !== 1'b1 || out_valid !== 1'b1)
            $display("FAIL underrun_set got u%b v%b want u1 v1", underrun, out_valid); else passed++;
        total++; if (out_left !== last_l || out_right !== last_r)
            $display("FAIL underrun_hold got %h/%h want %h/%h", out_left, out_right, last_l, last_r); else passed++;
        @(negedge clk) flag_clr = 1'b1;
        @(negedge clk) flag_clr = 1'b0;
        total++; if (underrun !== 1'b0 || overrun !== 1'b0)
            $display("FAIL flag_clr got u%b o%b want u0 o0", underrun, overrun); else passed++;
        @(negedge clk) out_tick = 1'b1;
        @(negedge clk) out_tick = 1'b0;
        total++; if (underrun !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL back_in_prime got u%b v%b want u0 v0", underrun, out_valid); else passed++;
    endtask

    task automatic test_push_pop_full();
        logic v, o;
        logic [15:0] l, r;
        logic [3:0] lv;
        frames(11, 8);
        exp_pair = exp_q.pop_front();
        send_frame(19, 1'b1, 1'b0, v, l, r, lv, o);
        total++; if (v !== 1'b1 || {l, r} !== exp_pair)
            $display("FAIL full_pushpop_out got v%b %h%h want v1 %h", v, l, r, exp_pair); else passed++;
        total++; if (lv !== 4'd8 || o !== 1'b0)
            $display("FAIL full_pushpop_level got %0d o%b want 8 o0", lv, o); else passed++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) out_tick = 1'b1;
            @(negedge clk) out_tick = 1'b0;
            exp_pair = exp_q.pop_front();
            total++; if (out_valid !== 1'b1 || {out_left, out_right} !== exp_pair)
                $display("FAIL after_pushpop%0d got v%b %h%h want v1 %h", i, out_valid, out_left, out_right, exp_pair);
            else passed++;
        end
    endtask

    task automatic test_enable_drop();
        logic v, o;
        logic [15:0] l, r;
        logic [3:0] lv;
        do_reset();
        frames(1, 5);
        total++; if (level !== 4'd5) $display("FAIL pre_drop_level got %0d want 5", level); else passed++;
        rx_left  = lval(6);
        rx_right = rval(6);
        @(negedge clk) rx_lrck = 1'b1;
        repeat (4) @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (level !== 4'd0) $display("FAIL drop_flush got %0d want 0", level); else passed++;
        enable = 1'b1;
        repeat (6) @(negedge clk);
        rx_lrck = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        total++; if (level !== 4'd0) $display("FAIL drop_no_push got %0d want 0", level); else passed++;
        @(negedge clk) out_tick = 1'b1;
        @(negedge clk) out_tick = 1'b0;
        total++; if (out_valid !== 1'b0 || underrun !== 1'b0)
            $display("FAIL drop_prime got v%b u%b want v0 u0", out_valid, underrun); else passed++;
        frames(1, 8);
        send_frame(9, 1'b0, 1'b1, v, l, r, lv, o);
        total++; if (overrun !== 1'b1) $display("FAIL clr_vs_set got %b want 1", overrun); else passed++;
        @(negedge clk) flag_clr = 1'b1;
        @(negedge clk) flag_clr = 1'b0;
        total++; if (overrun !== 1'b0) $display("FAIL clr_alone got %b want 0", overrun); else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        frames(1, 9);
        @(negedge clk) out_tick = 1'b1;
        @(negedge clk) out_tick = 1'b0;
        exp_pair = exp_q.pop_front();
        total++; if ({out_left, out_right} !== exp_pair || overrun !== 1'b1)
            $display("FAIL pre_reset got %h%h o%b want %h o1", out_left, out_right, overrun, exp_pair); else passed++;
        #2 reset = 1'b1;
        #1;
        total++; if (out_left !== 16'h0 || out_right !== 16'h0 || level !== 4'd0)
            $display("FAIL async_reset_out got %h/%h lvl %0d want 0/0/0", out_left, out_right, level); else passed++;
        total++; if (out_valid !== 1'b0 || overrun !== 1'b0 || underrun !== 1'b0)
            $display("FAIL async_reset_flags got v%b o%b u%b want 0", out_valid, overrun, underrun); else passed++;
        @(negedge clk) reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        rx_lrck  = 1'b0;
        rx_left  = 16'h0;
        rx_right = 16'h0;
        out_tick = 1'b0;
        flag_clr = 1'b0;
        last_l   = 16'h0;
        last_r   = 16'h0;
        test_reset();
        test_prime_play();
        test_overrun();
        test_underrun();
        test_push_pop_full();
        test_enable_drop();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout after %0d/%0d checks", passed, total);
        $fatal(1);
    end

endmodule
